// File: rtl/riscv_lite_pkg.sv
// Shared constants and types for the RISC-V Lite program-memory loader.
package riscv_lite_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/prog_mem_loader_if.sv
// Load-stream, fetch and status signals between the file reader/core and the loader.
interface prog_mem_loader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 7
);
    logic              LdValid;
    logic [DATA_W-1:0] LdData;
    logic              LdEOF;
    logic              LdReady;
    logic [ADDR_W-1:0] PC;
    logic [DATA_W-1:0] Instruction;
    logic              AddrErr;
    logic              CoreRst;
    logic              Loaded;
    logic [CNT_W-1:0]  LoadCount;
    logic              Overflow;

    modport master (
        output LdValid, LdData, LdEOF, PC,
        input  LdReady, Instruction, AddrErr, CoreRst, Loaded, LoadCount, Overflow
    );

    modport slave (
        input  LdValid, LdData, LdEOF, PC,
        output LdReady, Instruction, AddrErr, CoreRst, Loaded, LoadCount, Overflow
    );
endinterface

// File: rtl/prog_mem_array.sv
// Word storage with per-word valid bits and a registered, valid-gated read port.
module prog_mem_array
    import riscv_lite_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rsel,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    // Mark written words; read old contents so a same-cycle write is not bypassed
    always_comb begin
        valid_d = valid_q;
        rdata_d = DATA_W'(NOP_INSTR);
        if (we) begin
            valid_d[waddr] = 1'b1;
        end
        if (rsel && valid_q[raddr]) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Storage needs no reset: unwritten words are masked by their valid bit
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Valid bits and read register, cleared synchronously
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            rdata_q <= DATA_W'(NOP_INSTR);
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/prog_mem_loader.sv
// Instruction memory with program-load engine, core-reset sequencer and fetch decode.
module prog_mem_loader
    import riscv_lite_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    prog_mem_loader_if.slave bus
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    ld_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               ovf_q, ovf_d;
    logic               ld_ready_q, ld_ready_d;
    logic               core_rst_q, core_rst_d;
    logic               loaded_q, loaded_d;
    logic               addr_err_q, addr_err_d;
    logic               we_c;
    logic [ADDR_W-1:0]  off_c;
    logic               in_range_c;
    logic [IDX_W-1:0]   idx_c;

    // Fetch decode relative to the text base; misaligned or beyond-depth is a bad fetch
    always_comb begin
        off_c      = bus.PC - BASE_ADDR;
        in_range_c = (off_c[1:0] == 2'b00) && (off_c[ADDR_W-1:IDX_W+2] == '0);
        idx_c      = off_c[IDX_W+1:2];
        addr_err_d = !in_range_c;
    end

    // Load/hold/run sequencing and next values of the registered status outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        ovf_d   = ovf_q;
        we_c    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (bus.LdValid) begin
                    if (cnt_q < CNT_W'(DEPTH)) begin
                        we_c  = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                        if (!bus.LdEOF) begin
                            state_d = ST_ERR;
                        end
                    end
                end
                if (bus.LdEOF) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end
            end
            ST_HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RUN:  state_d = ST_RUN;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_LOAD;
        endcase
        ld_ready_d = (state_d == ST_LOAD);
        core_rst_d = (state_d != ST_RUN);
        loaded_d   = (state_d == ST_RUN);
    end

    // State and status registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            hold_q     <= '0;
            ovf_q      <= 1'b0;
            ld_ready_q <= 1'b1;
            core_rst_q <= 1'b1;
            loaded_q   <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            ovf_q      <= ovf_d;
            ld_ready_q <= ld_ready_d;
            core_rst_q <= core_rst_d;
            loaded_q   <= loaded_d;
            addr_err_q <= addr_err_d;
        end
    end

    prog_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (Clk),
        .rst   (Rst),
        .we    (we_c),
        .waddr (cnt_q[IDX_W-1:0]),
        .wdata (bus.LdData),
        .rsel  (in_range_c),
        .raddr (idx_c),
        .rdata (bus.Instruction)
    );

    assign bus.LdReady   = ld_ready_q;
    assign bus.CoreRst   = core_rst_q;
    assign bus.Loaded    = loaded_q;
    assign bus.LoadCount = cnt_q;
    assign bus.Overflow  = ovf_q;
    assign bus.AddrErr   = addr_err_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// Scoreboard bench: a 64-word loader and a 4-word loader share clock and reset.
module tb_prog_mem_loader;
    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        string       name;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q64[$];
    exp_t q4[$];
    logic req64 = 1'b0, req4 = 1'b0;
    logic pend64 = 1'b0, pend4 = 1'b0;

    prog_mem_loader_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(7)) b64 ();
    prog_mem_loader_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(3)) b4 ();

    prog_mem_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .BASE_ADDR(BASE), .HOLD_CYCLES(4))
        u64 (.Clk(Clk), .Rst(Rst), .bus(b64));
    prog_mem_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .BASE_ADDR(BASE), .HOLD_CYCLES(4))
        u4 (.Clk(Clk), .Rst(Rst), .bus(b4));

    always #5 Clk = ~Clk;

    // Mark which cycles carry a fetch response
    always @(posedge Clk) begin
        pend64 <= req64;
        pend4  <= req4;
    end

    // Monitor: compare each fetch response against the head of its queue
    always @(negedge Clk) begin
        exp_t e;
        if (pend64) begin
            n_checks++;
            if (q64.size() == 0) begin
                n_errors++;
                $display("FAIL fetch64 no expectation queued: got %h/%0b", b64.Instruction, b64.AddrErr);
            end else begin
                e = q64.pop_front();
                if (b64.Instruction !== e.instr || b64.AddrErr !== e.err) begin
                    n_errors++;
                    $display("FAIL %s: got %h/%0b expected %h/%0b", e.name, b64.Instruction, b64.AddrErr, e.instr, e.err);
                end
            end
        end
        if (pend4) begin
            n_checks++;
            if (q4.size() == 0) begin
                n_errors++;
                $display("FAIL fetch4 no expectation queued: got %h/%0b", b4.Instruction, b4.AddrErr);
            end else begin
                e = q4.pop_front();
                if (b4.Instruction !== e.instr || b4.AddrErr !== e.err) begin
                    n_errors++;
                    $display("FAIL %s: got %h/%0b expected %h/%0b", e.name, b4.Instruction, b4.AddrErr, e.instr, e.err);
                end
            end
        end
    end

    task automatic step();
        @(negedge Clk);
        req64 = 1'b0;
        req4  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fetch64(input logic [31:0] pc, input logic [31:0] instr, input logic err, input string name);
        exp_t e;
        e.instr = instr; e.err = err; e.name = name;
        b64.PC = pc;
        req64  = 1'b1;
        q64.push_back(e);
    endtask

    task automatic fetch4(input logic [31:0] pc, input logic [31:0] instr, input logic err, input string name);
        exp_t e;
        e.instr = instr; e.err = err; e.name = name;
        b4.PC = pc;
        req4  = 1'b1;
        q4.push_back(e);
    endtask

    task automatic pulse_reset();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
    endtask

    function automatic logic [31:0] full_word(input int i);
        return 32'hC000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[3];
        logic [31:0] a[5];
        w[0] = 32'h0050_0093; w[1] = 32'h00a0_0113; w[2] = 32'h0020_81b3;
        for (int i = 0; i < 5; i++) a[i] = 32'h1000_0000 + 32'(i);

        b64.LdValid = 0; b64.LdData = '0; b64.LdEOF = 0; b64.PC = BASE;
        b4.LdValid  = 0; b4.LdData  = '0; b4.LdEOF  = 0; b4.PC  = BASE;
        step(); step();
        chk("rst_ldready", 32'(b64.LdReady), 1);
        chk("rst_instr", b64.Instruction, NOP);
        chk("rst_addrerr", 32'(b64.AddrErr), 0);
        chk("rst_corerst", 32'(b64.CoreRst), 1);
        chk("rst_loaded", 32'(b64.Loaded), 0);
        chk("rst_count", 32'(b64.LoadCount), 0);
        chk("rst_overflow", 32'(b64.Overflow), 0);
        Rst = 1'b0;

        // Basic load: EOF with the third word
        b64.LdValid = 1; b64.LdData = w[0]; step();
        b64.LdData = w[1]; step();
        b64.LdData = w[2]; b64.LdEOF = 1; step();
        b64.LdValid = 0; b64.LdEOF = 0;
        chk("basic_count", 32'(b64.LoadCount), 3);
        chk("basic_hold_ldready", 32'(b64.LdReady), 0);
        chk("basic_hold_corerst", 32'(b64.CoreRst), 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("basic_hold_corerst_k", 32'(b64.CoreRst), 1);
        end
        step();
        chk("basic_run_corerst", 32'(b64.CoreRst), 0);
        chk("basic_run_loaded", 32'(b64.Loaded), 1);
        fetch64(32'h0040_0004, w[1], 0, "basic_pc4");          step();
        fetch64(32'h0040_000C, NOP, 0, "unwritten_pc0c");      step();
        fetch64(32'h0040_0002, NOP, 1, "misaligned_pc02");     step();
        fetch64(32'h003F_FFFC, NOP, 1, "below_base");          step();
        fetch64(32'h0040_0000, w[0], 0, "basic_pc0");          step();
        fetch64(32'h0040_0008, w[2], 0, "basic_pc8");          step();
        fetch64(32'h0040_0100, NOP, 1, "past_end");            step();
        step();

        // Overflow on the 4-deep loader, with read-during-write checks
        for (int i = 0; i < 5; i++) begin
            b4.LdValid = 1; b4.LdData = a[i];
            if (i == 1) fetch4(BASE + 32'd4, NOP, 0, "rdw_old_contents");
            if (i == 2) fetch4(BASE + 32'd4, a[1], 0, "rdw_after_write");
            step();
            if (i == 3) begin
                chk("ovf_full_count", 32'(b4.LoadCount), 4);
                chk("ovf_not_yet", 32'(b4.Overflow), 0);
                chk("ovf_full_ldready", 32'(b4.LdReady), 1);
            end
        end
        b4.LdValid = 0;
        chk("ovf_set", 32'(b4.Overflow), 1);
        chk("ovf_corerst", 32'(b4.CoreRst), 1);
        chk("ovf_ldready", 32'(b4.LdReady), 0);
        chk("ovf_count", 32'(b4.LoadCount), 4);
        chk("ovf_loaded", 32'(b4.Loaded), 0);
        for (int i = 0; i < 4; i++) begin
            fetch4(BASE + 32'(4 * i), a[i], 0, "ovf_readback");
            step();
        end
        b4.LdValid = 1; b4.LdEOF = 1; b4.LdData = 32'hFFFF_FFFF;
        step(); step();
        b4.LdValid = 0; b4.LdEOF = 0;
        chk("err_sticky_corerst", 32'(b4.CoreRst), 1);
        chk("err_sticky_ldready", 32'(b4.LdReady), 0);
        chk("err_sticky_overflow", 32'(b4.Overflow), 1);

        // Reset while running (64) and in error (4)
        pulse_reset();
        chk("rstrun_count", 32'(b64.LoadCount), 0);
        chk("rstrun_corerst", 32'(b64.CoreRst), 1);
        chk("rstrun_loaded", 32'(b64.Loaded), 0);
        chk("rstrun_ldready", 32'(b64.LdReady), 1);
        chk("rsterr_overflow", 32'(b4.Overflow), 0);
        chk("rsterr_ldready", 32'(b4.LdReady), 1);
        fetch64(BASE, NOP, 0, "rstrun_old_word");
        fetch4(BASE, NOP, 0, "rsterr_old_word");
        step(); step();

        // Reset during HOLD: EOF alone after two words
        b64.LdValid = 1; b64.LdData = w[0]; step();
        b64.LdData = w[1]; step();
        b64.LdValid = 0; b64.LdEOF = 1; step();
        b64.LdEOF = 0;
        chk("hold_count", 32'(b64.LoadCount), 2);
        step();
        chk("hold_ldready", 32'(b64.LdReady), 0);
        pulse_reset();
        chk("rsthold_count", 32'(b64.LoadCount), 0);
        chk("rsthold_corerst", 32'(b64.CoreRst), 1);
        chk("rsthold_loaded", 32'(b64.Loaded), 0);
        chk("rsthold_ldready", 32'(b64.LdReady), 1);
        fetch64(BASE + 32'd4, NOP, 0, "rsthold_old_word");
        for (int k = 0; k < 6; k++) step();
        chk("rsthold_stays_reset", 32'(b64.CoreRst), 1);

        // EOF without data
        b64.LdEOF = 1; step();
        b64.LdEOF = 0;
        chk("eof0_count", 32'(b64.LoadCount), 0);
        chk("eof0_ldready", 32'(b64.LdReady), 0);
        step(); step(); step();
        chk("eof0_hold_corerst", 32'(b64.CoreRst), 1);
        step();
        chk("eof0_run_corerst", 32'(b64.CoreRst), 0);
        chk("eof0_run_loaded", 32'(b64.Loaded), 1);
        fetch64(BASE, NOP, 0, "eof0_pc0");              step();
        fetch64(BASE + 32'd4, NOP, 0, "eof0_pc4");      step();
        fetch64(BASE + 32'd252, NOP, 0, "eof0_last");   step();
        fetch64(BASE + 32'd1, NOP, 1, "eof0_misalign"); step();
        step();

        // Full 64-word load with gaps, EOF on the last word
        pulse_reset();
        for (int i = 0; i < 64; i++) begin
            if (i % 3 == 2) begin
                b64.LdValid = 0; b64.LdData = 32'hDEAD_BEEF; step();
            end
            b64.LdValid = 1; b64.LdData = full_word(i); b64.LdEOF = (i == 63); step();
        end
        b64.LdValid = 0; b64.LdEOF = 0;
        chk("full_count", 32'(b64.LoadCount), 64);
        chk("full_overflow", 32'(b64.Overflow), 0);
        for (int k = 0; k < 10 && b64.Loaded !== 1'b1; k++) step();
        chk("full_loaded_within_budget", 32'(b64.Loaded), 1);
        for (int i = 0; i < 64; i++) begin
            fetch64(BASE + 32'(4 * i), full_word(i), 0, "full_readback");
            step();
        end
        fetch64(BASE + 32'd256, NOP, 1, "full_past_end"); step();
        step(); step();

        chk("queues_drained", 32'(q64.size() + q4.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
